// File: rtl/seg_capture.sv
// seg_capture: debounced capture of a multiplexed 4-digit seven-segment bus into a 16-bit hex value.
// Optional inter-digit timeout is enabled by defining SEG_CAPTURE_TIMEOUT_EN.
module seg_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  digit,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        err,
    output logic [1:0]  err_code
);
    typedef enum logic [1:0] {IDLE, COL1, COL2, COL3} state_t;

    state_t      r_state, w_state_n;
    logic [6:0]  r_dig_s1, r_dig_s2;
    logic [3:0]  r_an_s1, r_an_s2;
    logic [10:0] r_prev, w_s;
    logic [7:0]  r_cnt;
    logic [15:0] r_frame, w_frame_n, r_value;
    logic        r_bad, w_bad_n, r_vv, w_vv, r_err, w_err;
    logic [1:0]  r_code, w_code, w_k;
    logic [3:0]  w_nib;
    logic        w_same, w_accept, w_blank, w_one, w_pbad;

    assign w_s      = {r_an_s2, r_dig_s2};
    assign w_same   = w_s == r_prev;
    assign w_accept = w_same && r_cnt == 8'(STABLE_CYCLES - 1);
    assign w_blank  = r_an_s2 == 4'hF;
    assign w_one    = $onehot(~r_an_s2);
    assign w_k      = !r_an_s2[0] ? 2'd0 : !r_an_s2[1] ? 2'd1 : !r_an_s2[2] ? 2'd2 : 2'd3;

    // two-flop synchronizers, idle (all ones) out of reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dig_s1 <= '1;
            r_dig_s2 <= '1;
            r_an_s1  <= '1;
            r_an_s2  <= '1;
        end else begin
            r_dig_s1 <= digit;
            r_dig_s2 <= r_dig_s1;
            r_an_s1  <= an;
            r_an_s2  <= r_an_s1;
        end
    end

    // stability counter: clears on any change, saturates so accept fires once per window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= '1;
            r_cnt  <= '0;
        end else begin
            r_prev <= w_s;
            r_cnt  <= !w_same ? '0 : (r_cnt == 8'(STABLE_CYCLES)) ? r_cnt : r_cnt + 8'd1;
        end
    end

    // segment pattern to nibble; unknown patterns flag bad and store 0
    always_comb begin
        w_nib  = 4'h0;
        w_pbad = 1'b0;
        case (r_dig_s2)
            7'h40: w_nib = 4'h0;
            7'h79: w_nib = 4'h1;
            7'h24: w_nib = 4'h2;
            7'h30: w_nib = 4'h3;
            7'h19: w_nib = 4'h4;
            7'h12: w_nib = 4'h5;
            7'h02: w_nib = 4'h6;
            7'h78: w_nib = 4'h7;
            7'h00: w_nib = 4'h8;
            7'h10: w_nib = 4'h9;
            7'h08: w_nib = 4'hA;
            7'h03: w_nib = 4'hB;
            7'h46: w_nib = 4'hC;
            7'h21: w_nib = 4'hD;
            7'h06: w_nib = 4'hE;
            7'h0E: w_nib = 4'hF;
            default: w_pbad = 1'b1;
        endcase
    end

`ifdef SEG_CAPTURE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmr;
    logic          w_timeout;

    // an accept in the same cycle as expiry wins, so it masks the timeout
    assign w_timeout = r_state != IDLE && !w_accept && r_tmr == TW'(TIMEOUT_CYCLES - 1);

    // cycles since last accept while collecting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_tmr <= '0;
        else       r_tmr <= (r_state == IDLE || w_accept) ? '0 : r_tmr + 1'b1;
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // frame sequencing: next state, nibble storage and output pulses
    always_comb begin
        w_state_n = r_state;
        w_frame_n = r_frame;
        w_bad_n   = r_bad;
        w_vv      = 1'b0;
        w_err     = 1'b0;
        w_code    = r_code;
        if (w_accept && !w_blank) begin
            if (w_one && w_k == 2'd0) begin
                w_frame_n[3:0] = w_nib;
                w_bad_n        = w_pbad;
                w_state_n      = COL1;
                if (r_state != IDLE) begin
                    w_err  = 1'b1;
                    w_code = 2'b10;
                end
            end else if (r_state != IDLE) begin
                if (w_one && w_k == r_state) begin
                    w_frame_n[{w_k, 2'b00} +: 4] = w_nib;
                    w_bad_n                      = r_bad | w_pbad;
                    w_state_n                    = r_state == COL3 ? IDLE : state_t'(r_state + 2'd1);
                    if (r_state == COL3) begin
                        w_vv   = !w_bad_n;
                        w_err  = w_bad_n;
                        w_code = w_bad_n ? 2'b01 : r_code;
                    end
                end else begin
                    w_state_n = IDLE;
                    w_err     = 1'b1;
                    w_code    = 2'b10;
                end
            end
        end
`ifdef SEG_CAPTURE_TIMEOUT_EN
        if (w_timeout) begin
            w_state_n = IDLE;
            w_err     = 1'b1;
            w_code    = 2'b11;
        end
`endif
    end

    // state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_frame <= '0;
            r_bad   <= 1'b0;
            r_value <= '0;
            r_vv    <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= 2'b00;
        end else begin
            r_state <= w_state_n;
            r_frame <= w_frame_n;
            r_bad   <= w_bad_n;
            r_value <= w_vv ? w_frame_n : r_value;
            r_vv    <= w_vv;
            r_err   <= w_err;
            r_code  <= w_code;
        end
    end

    assign value       = r_value;
    assign value_valid = r_vv;
    assign err         = r_err;
    assign err_code    = r_code;
endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: directed scans with a scoreboard of expected value/err events.
module tb_seg_capture;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  digit = 7'h7F;
    logic [3:0]  an = 4'hF;
    logic [15:0] value;
    logic        value_valid, err;
    logic [1:0]  err_code;

    typedef struct packed {
        logic        is_err;
        logic [15:0] val;
        logic [1:0]  code;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] last_value = 16'h0;

    seg_capture #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .digit(digit), .an(an),
        .value(value), .value_valid(value_valid), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic exp_valid(input logic [15:0] v);
        q.push_back({1'b0, v, 2'b00});
    endtask

    task automatic exp_err(input logic [1:0] c);
        q.push_back({1'b1, 16'h0, c});
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] p, input int n);
        an = a;
        digit = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [6:0] p0, p1, p2, p3, input int n);
        hold(4'b1110, p0, n);
        hold(4'b1101, p1, n);
        hold(4'b1011, p2, n);
        hold(4'b0111, p3, n);
        hold(4'b1111, 7'h7F, 12);
    endtask

    // monitor: pop and compare on every output event
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (value_valid && err) begin
                checks++;
                failures++;
                $display("FAIL overlap value_valid=1 err=1 required=exclusive");
            end
            if (value_valid || err) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event valid=%0b err=%0b code=%0b value=%h required=none",
                             value_valid, err, err_code, value);
                end else begin
                    e = q.pop_front();
                    check("event_is_err", {31'h0, err}, {31'h0, e.is_err});
                    if (e.is_err) check("err_code", {30'h0, err_code}, {30'h0, e.code});
                    else check("value", {16'h0, value}, {16'h0, e.val});
                end
            end
            if (value !== last_value && !value_valid) begin
                checks++;
                failures++;
                $display("FAIL value_change_without_valid actual=%h required=%h", value, last_value);
            end
        end
        last_value = value;
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_value", {16'h0, value}, 32'h0);
        check("rst_valid", {31'h0, value_valid}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_code", {30'h0, err_code}, 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        exp_valid(16'h0123);
        frame(7'h30, 7'h24, 7'h79, 7'h40, 8);

        exp_err(2'b01);
        frame(7'h30, 7'h24, 7'h7F, 7'h40, 8);
        check("bad_value_hold", {16'h0, value}, 32'h0123);
        check("bad_code_held", {30'h0, err_code}, 32'h1);

        exp_err(2'b10);
        hold(4'b1110, 7'h30, 8);
        hold(4'b1011, 7'h79, 8);
        hold(4'b1111, 7'h7F, 12);
        hold(4'b1101, 7'h24, 8);
        hold(4'b1011, 7'h79, 8);
        hold(4'b0111, 7'h40, 8);
        hold(4'b1111, 7'h7F, 12);
        check("seq_code_held", {30'h0, err_code}, 32'h2);

        exp_err(2'b10);
        exp_valid(16'h0124);
        hold(4'b1110, 7'h30, 8);
        frame(7'h19, 7'h24, 7'h79, 7'h40, 8);

        exp_err(2'b10);
        hold(4'b1110, 7'h30, 8);
        hold(4'b1100, 7'h40, 8);
        hold(4'b1111, 7'h7F, 12);

        exp_valid(16'hDCBA);
        frame(7'h08, 7'h03, 7'h46, 7'h21, 8);
        exp_valid(16'h75FE);
        frame(7'h06, 7'h0E, 7'h12, 7'h78, 8);
        exp_valid(16'h4986);
        frame(7'h02, 7'h00, 7'h10, 7'h19, 8);

        frame(7'h30, 7'h24, 7'h79, 7'h40, 3);
        check("short_value_hold", {16'h0, value}, 32'h4986);

`ifdef SEG_CAPTURE_TIMEOUT_EN
        exp_err(2'b11);
        hold(4'b1110, 7'h30, 8);
        hold(4'b1111, 7'h7F, 40);
        check("timeout_code", {30'h0, err_code}, 32'h3);
`else
        hold(4'b1110, 7'h30, 8);
        hold(4'b1111, 7'h7F, 40);
        check("no_timeout_code", {30'h0, err_code}, 32'h2);
        exp_err(2'b10);
`endif
        hold(4'b1011, 7'h79, 8);
        hold(4'b1111, 7'h7F, 12);

        exp_valid(16'h0123);
        frame(7'h30, 7'h24, 7'h79, 7'h40, 8);
        hold(4'b1110, 7'h30, 8);
        hold(4'b1101, 7'h24, 8);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_value", {16'h0, value}, 32'h0);
        check("midrst_valid", {31'h0, value_valid}, 32'h0);
        check("midrst_err", {31'h0, err}, 32'h0);
        check("midrst_code", {30'h0, err_code}, 32'h0);
        hold(4'b1111, 7'h7F, 3);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        exp_valid(16'h75FE);
        frame(7'h06, 7'h0E, 7'h12, 7'h78, 8);

        repeat (20) @(negedge clk);
        check("queue_drained", q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
